// File: rtl/sound_voice_pdm_pkg.sv
// Shared voice definitions: FSM encodings, envelope ceiling and the sample scaler.
// Combinational helpers only; no timing or flow-control behaviour of its own.
package sound_voice_pdm_pkg;

  typedef enum logic [1:0] {
    VOICE_IDLE    = 2'd0,
    VOICE_RESTART = 2'd1,
    VOICE_PLAY    = 2'd2
  } voice_state_e;

  localparam logic [7:0] VOICE_VOL_MAX = 8'd255;

  // Signed sample times unsigned 8-bit volume, keeping product bits [23:8].
  function automatic logic [15:0] scale_sample(input logic [15:0] w, input logic [7:0] vol);
    logic signed [23:0] w_ext;
    logic signed [23:0] v_ext;
    logic signed [23:0] prod;
    w_ext = {{8{w[15]}}, w};
    v_ext = {16'd0, vol};
    prod  = w_ext * v_ext;
    return 16'(prod >>> 8);
  endfunction

endpackage

// File: rtl/sigma_delta_1bit.sv
// First-order 1-bit sigma-delta modulator on an offset-binary input; output is the registered carry.
// One cycle from input to out; clr zeroes accumulator and output; never stalls.
module sigma_delta_1bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] in,
  output logic        out
);

  logic [15:0] acc;
  logic [16:0] sum;

  assign sum = {1'b0, acc} + {1'b0, in};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      out <= 1'b0;
    end else begin
      acc <= sum[15:0];
      out <= sum[16];
    end
  end

endmodule

// File: rtl/sound_voice_pdm.sv
// Single sound-effect voice: restarts/paces the sinewaver, applies a decaying envelope, emits PDM audio.
// req -> wave_rst next cycle, PLAY one cycle later; sample/audio lag wave_in by 1/2 cycles; req always accepted.
module sound_voice_pdm
  import sound_voice_pdm_pkg::*;
#(
  parameter int PITCH_W = 12,
  parameter int STEP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [PITCH_W-1:0] pitch,
  input  logic [STEP_W-1:0]  dur,
  output logic               wave_rst,
  output logic               wave_trigger,
  input  logic [15:0]        wave_in,
  output logic               busy,
  output logic               audio
);

  voice_state_e       state, state_n;
  logic [PITCH_W-1:0] pr, divcnt, divcnt_n;
  logic [STEP_W-1:0]  dr, stepcnt, stepcnt_n;
  logic [7:0]         volume, volume_n;
  logic [15:0]        sample;
  logic               sd_clr;

  always_comb begin
    state_n   = state;
    divcnt_n  = divcnt;
    stepcnt_n = stepcnt;
    volume_n  = volume;
    unique case (state)
      VOICE_IDLE: state_n = VOICE_IDLE;
      VOICE_RESTART: begin
        divcnt_n  = pr;
        stepcnt_n = dr;
        volume_n  = VOICE_VOL_MAX;
        state_n   = VOICE_PLAY;
      end
      VOICE_PLAY: begin
        if (divcnt == '0) begin
          divcnt_n = pr;
          if (stepcnt == '0) begin
            stepcnt_n = dr;
            if (volume == 8'd1) state_n = VOICE_IDLE;
            else                volume_n = volume - 8'd1;
          end else begin
            stepcnt_n = stepcnt - STEP_W'(1);
          end
        end else begin
          divcnt_n = divcnt - PITCH_W'(1);
        end
      end
      default: state_n = VOICE_IDLE;
    endcase
    // A new request beats everything, including the final envelope step.
    if (req) state_n = VOICE_RESTART;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= VOICE_IDLE;
      pr           <= '0;
      dr           <= '0;
      divcnt       <= '0;
      stepcnt      <= '0;
      volume       <= '0;
      wave_trigger <= 1'b0;
      sample       <= '0;
    end else begin
      state   <= state_n;
      divcnt  <= divcnt_n;
      stepcnt <= stepcnt_n;
      volume  <= volume_n;
      if (req) begin
        pr <= pitch;
        dr <= dur;
      end
      // Look ahead one cycle so the trigger register lines up with divcnt==0 in PLAY.
      wave_trigger <= (state_n == VOICE_PLAY) && (divcnt_n == '0);
      sample       <= (state == VOICE_PLAY) ? scale_sample(wave_in, volume) : '0;
    end
  end

  assign wave_rst = (state == VOICE_RESTART);
  assign busy     = (state != VOICE_IDLE);
  assign sd_clr   = (state == VOICE_IDLE) || (state_n == VOICE_IDLE);

  sigma_delta_1bit u_sd (
    .clk (clk),
    .rst (rst),
    .clr (sd_clr),
    .in  ({~sample[15], sample[14:0]}),
    .out (audio)
  );

endmodule

// File: tb/tb_sound_voice_pdm.sv
// Directed-plus-random bench for sound_voice_pdm against a closed-form tone model.
module tb_sound_voice_pdm;

  logic        clk, rst, req, wave_rst, wave_trigger, busy, audio;
  logic [11:0] pitch;
  logic [7:0]  dur;
  logic [15:0] wave_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: k = cycles since the latest accepted req (0 = idle, 1 = restart, k>=2 = PLAY cycle k-2).
  int          k = 0;
  int          mp = 0;
  int          md = 0;
  bit          prev_idle = 1'b1;
  bit          chk_en = 1'b0;
  logic [15:0] exp_samp = '0;
  int          n_trig, n_wrst, n_play, n_ones, n_busy;

  sound_voice_pdm #(.PITCH_W(12), .STEP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .pitch        (pitch),
    .dur          (dur),
    .wave_rst     (wave_rst),
    .wave_trigger (wave_trigger),
    .wave_in      (wave_in),
    .busy         (busy),
    .audio        (audio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_trig = 0; n_wrst = 0; n_play = 0; n_ones = 0; n_busy = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input bit r, input bit q, input int p, input int d, input logic [15:0] w);
    int per, tot, m, vol;
    bit play, trig_e;
    rst = r; req = q; pitch = 12'(p); dur = 8'(d); wave_in = w;
    @(negedge clk);
    per    = mp + 1;
    tot    = 255 * (md + 1) * per;
    play   = (k >= 2);
    m      = k - 2;
    trig_e = play && ((m % per) == per - 1);
    vol    = play ? 255 - (m / per) / (md + 1) : 0;
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(k != 0));
      chk("wave_rst", 32'(wave_rst), 32'(k == 1));
      chk("wave_trigger", 32'(wave_trigger), 32'(trig_e));
      chk("sample", 32'(dut.sample), 32'(exp_samp));
      if (play) chk("volume", 32'(dut.volume), 32'(vol));
      if (k == 0 || (k == 1 && prev_idle)) chk("audio_silent", 32'(audio), 32'(0));
    end
    if (wave_trigger) n_trig++;
    if (wave_rst) n_wrst++;
    if (busy) n_busy++;
    if (busy && !wave_rst) n_play++;
    if (audio) n_ones++;
    exp_samp  = play ? 16'((int'($signed(w)) * vol) >>> 8) : 16'h0;
    prev_idle = (k == 0);
    if (r) begin
      k = 0; exp_samp = 16'h0;
    end else if (q) begin
      k = 1; mp = p; md = d;
    end else if (k != 0) begin
      k++;
      if (k >= 2 && (k - 2) >= tot) k = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle1(input logic [15:0] w);
    cyc(1'b0, 1'b0, int'($urandom_range(4095, 0)), int'($urandom_range(255, 0)), w);
  endtask

  task automatic play_out(input int budget);
    for (int i = 0; i < budget && k != 0; i++) idle1(16'($urandom));
    if (k != 0) chk("timeout", 32'(k), 32'(0));
  endtask

  initial begin
    int p, d;
    rst = 1'b1; req = 1'b0; pitch = '0; dur = '0; wave_in = 16'h7FFF;
    repeat (3) cyc(1'b1, 1'b0, 0, 0, 16'h7FFF);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 5, 5, 16'h7FFF);
    chk("rst_volume", 32'(dut.volume), 32'(0));
    chk("rst_acc", 32'(dut.u_sd.acc), 32'(0));

    // Idle with full-scale input: nothing may move.
    clr_counts();
    repeat (100) idle1(16'h7FFF);
    chk("idle_activity", 32'(n_busy + n_wrst + n_trig + n_ones), 32'(0));

    // pitch=3, dur=0.
    clr_counts();
    cyc(1'b0, 1'b1, 3, 0, 16'($urandom));
    play_out(2000);
    chk("p3_triggers", 32'(n_trig), 32'(255));
    chk("p3_wave_rst", 32'(n_wrst), 32'(1));
    chk("p3_play_cycles", 32'(n_play), 32'(1020));
    repeat (3) idle1(16'($urandom));

    // pitch=0, dur=1.
    clr_counts();
    cyc(1'b0, 1'b1, 0, 1, 16'($urandom));
    play_out(2000);
    chk("p0_triggers", 32'(n_trig), 32'(510));
    chk("p0_play_cycles", 32'(n_play), 32'(510));
    repeat (3) idle1(16'($urandom));

    // Random tones, each new req landing on the previous tone's final step.
    cyc(1'b0, 1'b1, int'($urandom_range(2, 0)), int'($urandom_range(1, 0)), 16'($urandom));
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3000 && !(k >= 2 && (k - 2) == 255 * (md + 1) * (mp + 1) - 1); i++)
        idle1(16'($urandom));
      p = int'($urandom_range(2, 0));
      d = int'($urandom_range(1, 0));
      cyc(1'b0, 1'b1, p, d, 16'($urandom));
    end
    play_out(4000);
    repeat (3) idle1(16'($urandom));

    // Back-to-back req in RESTART, retrigger at PLAY cycle 50, reset at PLAY cycle 20.
    cyc(1'b0, 1'b1, 7, 0, 16'($urandom));
    cyc(1'b0, 1'b1, 2, 0, 16'($urandom));
    repeat (51) idle1(16'($urandom));
    clr_counts();
    cyc(1'b0, 1'b1, 5, 1, 16'($urandom));
    idle1(16'($urandom));
    idle1(16'($urandom));
    chk("retrig_wave_rst", 32'(n_wrst), 32'(1));
    chk("retrig_volume", 32'(dut.volume), 32'(255));
    repeat (19) idle1(16'($urandom));
    cyc(1'b1, 1'b0, 0, 0, 16'($urandom));
    chk("rst_mid_outputs", 32'({busy, wave_rst, wave_trigger, audio}), 32'(0));
    repeat (5) idle1(16'($urandom));

    // PDM density with a held input and full volume.
    cyc(1'b0, 1'b1, 4095, 255, 16'h4000);
    repeat (4) idle1(16'h4000);
    chk("sample_4000", 32'(dut.sample), 32'(16'h3FC0));
    clr_counts();
    repeat (65536) idle1(16'h4000);
    chk("ones_4000", 32'(n_ones), 32'(49088));
    repeat (3) idle1(16'h8000);
    chk("sample_8000", 32'(dut.sample), 32'(16'h8080));
    clr_counts();
    repeat (4096) idle1(16'h8000);
    chk("ones_8000", 32'(n_ones), 32'(8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
